data_mem_pipe: RTL and testbench
================================

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 Parameter DEPTH, default 8192, data memory size in bytes; power of two, minimum 16.
REQ-002 Parameter LATENCY, default 1, cycles from request accept to response; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  memory-stage request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 icode  input  4  Y86-64 instruction code.
REQ-008 valE  input  64  ALU result; address for rmmovq, mrmovq, call, pushq.
REQ-009 valA  input  64  store data, or address for ret and popq.
REQ-010 valP  input  64  return address, stored by call.
REQ-011 instr_valid  input  1  fetch decoded a legal instruction.
REQ-012 imem_error  input  1  fetch address fault.
REQ-013 rsp_valid  output  1  one-cycle pulse; valM and stat are valid.
REQ-014 valM  output  64  read data; 0 for non-read operations.
REQ-015 stat  output  2  00 AOK, 01 HLT, 10 ADR, 11 INS.
REQ-016 dmem_err  output  1  data address fault, qualified by rsp_valid.

Function
REQ-017 Operation decode:
  - Writes: rmmovq(4) stores valA at valE; call(8) stores valP at valE; pushq(A) stores valA at valE.
  - Reads: mrmovq(5) reads valE; ret(9) reads valA; popq(B) reads valA.
  - Every other icode performs no access.
REQ-018 Accesses are 8 bytes, little-endian; byte at addr holds bits [7:0].
REQ-019 dmem_err is 1 when a read or write has addr > DEPTH-8 (unsigned 64-bit compare, no wrap).
  - A faulting write modifies no byte.
  - A faulting read returns valM = 0.
REQ-020 stat priority: imem_error -> ADR; else !instr_valid -> INS; else dmem_err -> ADR; else icode==0 -> HLT; else AOK.
REQ-021 imem_error=1 or instr_valid=0 suppresses the memory access; the response still issues after LATENCY cycles.
REQ-022 State machine:
  - IDLE -> BUSY on req_valid & req_ready; inputs are latched in the same edge.
  - BUSY holds while an internal counter counts LATENCY-1 down to 0.
  - BUSY -> IDLE when the count expires; rsp_valid=1 for that cycle.
REQ-023 Write commit timing: the write commits on the edge that raises rsp_valid.
  - A read issued in the following cycle returns the new data.
REQ-024 req_ready=1 only in IDLE; while BUSY, req_valid is ignored and latched inputs are not overwritten.
REQ-025 With LATENCY=1, rsp_valid rises on the edge after accept.
  - Back-to-back requests sustain one response every 2 cycles.
REQ-026 valM, stat and dmem_err hold their values until the next rsp_valid.

Reset
REQ-027 On rst=0: state=IDLE, counter=0, rsp_valid=0, valM=0, stat=00, dmem_err=0, req_ready=1, asynchronously.
REQ-028 Memory array contents are not cleared by reset.
REQ-029 Reset during BUSY aborts the operation with no write committed and no response.

Structure
REQ-030 Shared package y86_pkg holds:
  - icode constants (IHALT..IPOPQ);
  - stat encodings (STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS);
  - function addr_bits(DEPTH) returning clog2.
REQ-031 Byte storage is the single sub-module dmem_bytes.
  - Parameter DEPTH; 8-byte write port; 8-byte read port; no reset.
REQ-032 Decode, fault check, counter and FSM reside in data_mem_pipe.

Verification
REQ-033 Store/load: rmmovq valE=58 valA=12, then mrmovq valE=58 -> valM=12, stat=00, dmem_err=0.
REQ-034 Call/ret: call valE=58 valP=11, then ret valA=58 -> valM=11, stat=00.
REQ-035 Fault: rmmovq valE=DEPTH-4 valA=5 -> stat=10, dmem_err=1; mrmovq valE=DEPTH-8 -> prior contents unchanged.
REQ-036 Priority: imem_error=1 with icode=5 -> stat=10, valM=0; instr_valid=0 with icode=4 -> stat=11, no write.
REQ-037 Timing, LATENCY=3: accept at cycle 0 -> rsp_valid only at cycle 3, req_ready=0 in cycles 1-3, and a request pulsed at cycle 2 is dropped.
REQ-038 Reset: rst=0 in cycle 1 of a LATENCY=3 pushq -> no rsp_valid, no write, all outputs at reset values, req_ready=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status encodings and the
// memory-stage request record used by the data memory pipeline.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        STAT_AOK = 2'b00,
        STAT_HLT = 2'b01,
        STAT_ADR = 2'b10,
        STAT_INS = 2'b11
    } stat_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [63:0] val_p;
        logic        instr_valid;
        logic        imem_error;
    } mem_req_t;

    function automatic int addr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_bytes.sv
// Byte-addressed data store with one 8-byte little-endian write port and
// one 8-byte combinational read port.
module dmem_bytes
    import y86_pkg::*;
#(
    parameter  int DEPTH = 8192,
    localparam int AW    = addr_bits(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [7:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset; clearing thousands of bytes would
    // force flops instead of RAM, and contents must survive a reset anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem[waddr + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem[raddr + AW'(i)];
        end
    end

endmodule

// File: rtl/data_mem_pipe.sv
// Y86-64 memory stage: decodes the access, checks the address range and
// answers each accepted request after LATENCY cycles with valM/stat.
module data_mem_pipe
    import y86_pkg::*;
#(
    parameter int DEPTH   = 8192,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imem_error,
    output logic        rsp_valid,
    output logic [63:0] valM,
    output logic [1:0]  stat,
    output logic        dmem_err
);

    localparam int          AW       = addr_bits(DEPTH);
    localparam logic [63:0] MAX_ADDR = 64'(DEPTH - 8);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam bit          FAST     = (LATENCY == 1);

    mem_state_t  state, state_nx;
    logic [3:0]  cnt;
    mem_req_t    req_q, cur;
    logic        accept, fire;
    logic        is_write, is_read, suppress, fault, we;
    logic [63:0] addr, wdata, rdata;
    stat_t       stat_nx, stat_q;

    // The result is produced on the edge that enters the response cycle; with
    // LATENCY=1 that is the accept edge itself, so operate on the live inputs.
    always_comb begin
        cur = (state == ST_IDLE) ? mem_req_t'{icode, valE, valA, valP, instr_valid, imem_error}
                                 : req_q;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == 4'd0) begin
                    rsp_valid = 1'b1;
                    state_nx  = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        fire = FAST ? accept : (state == ST_BUSY && cnt == 4'd1);
    end

    always_comb begin
        is_write = cur.icode inside {IRMMOVQ, ICALL, IPUSHQ};
        is_read  = cur.icode inside {IMRMOVQ, IRET, IPOPQ};
        addr     = (cur.icode inside {IRET, IPOPQ}) ? cur.val_a : cur.val_e;
        wdata    = (cur.icode == ICALL) ? cur.val_p : cur.val_a;
        suppress = cur.imem_error | ~cur.instr_valid;
        fault    = (is_read | is_write) & ~suppress & (addr > MAX_ADDR);
        we       = fire & is_write & ~suppress & ~fault;

        if (cur.imem_error)        stat_nx = STAT_ADR;
        else if (!cur.instr_valid) stat_nx = STAT_INS;
        else if (fault)            stat_nx = STAT_ADR;
        else if (cur.icode == IHALT) stat_nx = STAT_HLT;
        else                       stat_nx = STAT_AOK;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            req_q <= '0;
        end else if (accept) begin
            cnt   <= CNT_INIT;
            req_q <= cur;
        end else if (state == ST_BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valM     <= '0;
            stat_q   <= STAT_AOK;
            dmem_err <= 1'b0;
        end else if (fire) begin
            valM     <= (is_read & ~suppress & ~fault) ? rdata : 64'd0;
            stat_q   <= stat_nx;
            dmem_err <= fault;
        end
    end

    assign stat = stat_q;

    dmem_bytes #(.DEPTH(DEPTH)) u_bytes (
        .clk   (clk),
        .we    (we),
        .waddr (addr[AW-1:0]),
        .wdata (wdata),
        .raddr (addr[AW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: a LATENCY=1 and a LATENCY=3 instance
// share the request inputs and are selected by their own req_valid.
module tb_data_mem_pipe;
    import y86_pkg::*;

    localparam int DEPTH = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rv1 = 1'b0, rv3 = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic [63:0] valE = '0, valA = '0, valP = '0;
    logic        instr_valid = 1'b1, imem_error = 1'b0;

    logic        rdy1, rsp1, err1, rdy3, rsp3, err3;
    logic [63:0] valm1, valm3;
    logic [1:0]  stat1, stat3;

    int          n_pass = 0, n_fail = 0, n_total = 0;
    logic [63:0] r_valm;
    logic [1:0]  r_stat;
    logic        r_err;
    int          r_lat;
    logic        saw_rsp;

    always #5 clk = ~clk;

    data_mem_pipe #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .icode(icode),
        .valE(valE), .valA(valA), .valP(valP), .instr_valid(instr_valid),
        .imem_error(imem_error), .rsp_valid(rsp1), .valM(valm1), .stat(stat1),
        .dmem_err(err1)
    );

    data_mem_pipe #(.DEPTH(DEPTH), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rdy3), .icode(icode),
        .valE(valE), .valA(valA), .valP(valP), .instr_valid(instr_valid),
        .imem_error(imem_error), .rsp_valid(rsp3), .valM(valm3), .stat(stat3),
        .dmem_err(err3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request to the selected instance and capture its response,
    // checking that it arrives after exactly LATENCY cycles.
    task automatic send(input bit slow, input logic [3:0] ic, input logic [63:0] e,
                        input logic [63:0] a, input logic [63:0] p,
                        input logic iv, input logic ie);
        @(negedge clk);
        icode = ic; valE = e; valA = a; valP = p; instr_valid = iv; imem_error = ie;
        if (slow) rv3 = 1'b1;
        else      rv1 = 1'b1;
        @(posedge clk);
        #1;
        rv1 = 1'b0;
        rv3 = 1'b0;
        r_lat = -1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if ((slow ? rsp3 : rsp1) === 1'b1) begin
                r_lat  = k;
                r_valm = slow ? valm3 : valm1;
                r_stat = slow ? stat3 : stat1;
                r_err  = slow ? err3 : err1;
                break;
            end
        end
        check(slow ? "latency3" : "latency1", 64'(r_lat), slow ? 64'd3 : 64'd1);
    endtask

    task automatic op(input bit slow, input logic [3:0] ic, input logic [63:0] e,
                      input logic [63:0] a, input logic [63:0] p);
        send(slow, ic, e, a, p, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready1", 64'(rdy1), 64'd1);
        check("rst_rsp1",   64'(rsp1), 64'd0);
        check("rst_valm1",  valm1,     64'd0);
        check("rst_stat1",  64'(stat1), 64'd0);
        check("rst_err1",   64'(err1), 64'd0);
        check("rst_ready3", 64'(rdy3), 64'd1);
        rst = 1'b1;

        // Store then load
        op(0, IRMMOVQ, 64'd58, 64'd12, 64'd0);
        check("st_stat", 64'(r_stat), 64'(STAT_AOK));
        check("st_valm", r_valm, 64'd0);
        op(0, IMRMOVQ, 64'd58, 64'd0, 64'd0);
        check("ld_valm", r_valm, 64'd12);
        check("ld_stat", 64'(r_stat), 64'(STAT_AOK));
        check("ld_err",  64'(r_err), 64'd0);
        @(negedge clk);
        check("hold_rsp",  64'(rsp1), 64'd0);
        check("hold_valm", valm1, 64'd12);

        // Call / ret
        op(0, ICALL, 64'd58, 64'd0, 64'd11);
        op(0, IRET, 64'd0, 64'd58, 64'd0);
        check("ret_valm", r_valm, 64'd11);
        check("ret_stat", 64'(r_stat), 64'(STAT_AOK));

        // Little-endian layout across an unaligned read
        op(0, IPUSHQ, 64'd200, 64'h8877_6655_4433_2211, 64'd0);
        op(0, IRMMOVQ, 64'd208, 64'hFFEE_DDCC_BBAA_9988, 64'd0);
        op(0, IMRMOVQ, 64'd204, 64'd0, 64'd0);
        check("le_valm", r_valm, 64'hBBAA_9988_8877_6655);
        op(0, IPOPQ, 64'd0, 64'd208, 64'd0);
        check("pop_valm", r_valm, 64'hFFEE_DDCC_BBAA_9988);

        // Address fault boundary
        op(0, IRMMOVQ, 64'(DEPTH - 8), 64'h1111, 64'd0);
        check("edge_err", 64'(r_err), 64'd0);
        op(0, IRMMOVQ, 64'(DEPTH - 4), 64'd5, 64'd0);
        check("flt_stat", 64'(r_stat), 64'(STAT_ADR));
        check("flt_err",  64'(r_err), 64'd1);
        op(0, IMRMOVQ, 64'(DEPTH - 8), 64'd0, 64'd0);
        check("flt_nowrite", r_valm, 64'h1111);
        check("flt_rd_err0", 64'(r_err), 64'd0);
        op(0, IPOPQ, 64'd0, 64'(DEPTH - 7), 64'd0);
        check("flt_rd_valm", r_valm, 64'd0);
        check("flt_rd_err",  64'(r_err), 64'd1);
        op(0, IMRMOVQ, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0);
        check("flt_huge_stat", 64'(r_stat), 64'(STAT_ADR));

        // Status priority and access suppression
        send(0, IMRMOVQ, 64'd58, 64'd0, 64'd0, 1'b1, 1'b1);
        check("imem_stat", 64'(r_stat), 64'(STAT_ADR));
        check("imem_valm", r_valm, 64'd0);
        send(0, IRMMOVQ, 64'd58, 64'd99, 64'd0, 1'b0, 1'b0);
        check("ins_stat", 64'(r_stat), 64'(STAT_INS));
        send(0, IHALT, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        check("both_stat", 64'(r_stat), 64'(STAT_ADR));
        op(0, IMRMOVQ, 64'd58, 64'd0, 64'd0);
        check("ins_nowrite", r_valm, 64'd11);
        op(0, IHALT, 64'd0, 64'd0, 64'd0);
        check("hlt_stat", 64'(r_stat), 64'(STAT_HLT));
        op(0, INOP, 64'd0, 64'd0, 64'd0);
        check("nop_stat", 64'(r_stat), 64'(STAT_AOK));

        // Back-to-back throughput at LATENCY=1
        @(negedge clk);
        icode = INOP;
        rv1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 4) rv1 = 1'b0;
            check("b2b_rsp",   64'(rsp1), 64'(i % 2));
            check("b2b_ready", 64'(rdy1), 64'((i + 1) % 2));
        end

        // LATENCY=3 timing with a dropped request while busy
        @(negedge clk);
        icode = IRMMOVQ; valE = 64'd300; valA = 64'hAA; instr_valid = 1'b1; imem_error = 1'b0;
        rv3 = 1'b1;
        @(posedge clk);
        #1 rv3 = 1'b0;
        @(negedge clk);
        check("t3_c1_rsp",   64'(rsp3), 64'd0);
        check("t3_c1_ready", 64'(rdy3), 64'd0);
        @(negedge clk);
        check("t3_c2_rsp",   64'(rsp3), 64'd0);
        check("t3_c2_ready", 64'(rdy3), 64'd0);
        valA = 64'hBB;
        rv3 = 1'b1;
        @(posedge clk);
        #1 rv3 = 1'b0;
        @(negedge clk);
        check("t3_c3_rsp",   64'(rsp3), 64'd1);
        check("t3_c3_ready", 64'(rdy3), 64'd0);
        @(negedge clk);
        check("t3_c4_rsp",   64'(rsp3), 64'd0);
        check("t3_c4_ready", 64'(rdy3), 64'd1);
        @(negedge clk);
        check("t3_c5_rsp",   64'(rsp3), 64'd0);
        op(1, IMRMOVQ, 64'd300, 64'd0, 64'd0);
        check("t3_drop_valm", r_valm, 64'hAA);

        // Reset in cycle 1 of a LATENCY=3 pushq
        op(1, IRMMOVQ, 64'd400, 64'h55, 64'd0);
        op(1, IMRMOVQ, 64'd400, 64'd0, 64'd0);
        check("pre_rst_valm", r_valm, 64'h55);
        @(negedge clk);
        icode = IPUSHQ; valE = 64'd400; valA = 64'h77;
        rv3 = 1'b1;
        @(posedge clk);
        #1 rv3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_ready", 64'(rdy3), 64'd1);
        check("arst_rsp",   64'(rsp3), 64'd0);
        check("arst_valm",  valm3, 64'd0);
        check("arst_stat",  64'(stat3), 64'd0);
        check("arst_err",   64'(err3), 64'd0);
        saw_rsp = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_rsp = saw_rsp | rsp3;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            saw_rsp = saw_rsp | rsp3;
        end
        check("arst_no_rsp", 64'(saw_rsp), 64'd0);
        op(1, IMRMOVQ, 64'd400, 64'd0, 64'd0);
        check("arst_nowrite", r_valm, 64'h55);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
